// File: rtl/axis_frame_arb.sv
// Two-source, frame-granular round-robin AXI4-Stream arbiter.
// A granted source owns the output from its first beat through tlast.
// Output is one registered stage with full tready backpressure.
// Optional per-source frame counters: define AXIS_FRAME_ARB_STATS_EN.
module axis_frame_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DATA_W-1:0]   s0_tdata,
    input  logic                s0_tvalid,
    input  logic                s0_tlast,
    output logic                s0_tready,
    input  logic [DATA_W-1:0]   s1_tdata,
    input  logic                s1_tvalid,
    input  logic                s1_tlast,
    output logic                s1_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic [DATA_W/8-1:0] m_axis_tstrb,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic [1:0]          grant,
    output logic [CNT_W-1:0]    frame_cnt0,
    output logic [CNT_W-1:0]    frame_cnt1
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_rr_ptr;
    logic              w_rr_ptr_next;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;

    logic w_out_free;
    logic w_acc0;
    logic w_acc1;
    logic w_end0;
    logic w_end1;

    // Output stage can take a beat when empty or draining this cycle.
    assign w_out_free = !r_tvalid || m_axis_tready;
    assign s0_tready  = (r_state == StGnt0) && w_out_free;
    assign s1_tready  = (r_state == StGnt1) && w_out_free;
    assign w_acc0     = s0_tvalid && s0_tready;
    assign w_acc1     = s1_tvalid && s1_tready;
    assign w_end0     = w_acc0 && s0_tlast;
    assign w_end1     = w_acc1 && s1_tlast;

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tstrb  = {(DATA_W/8){1'b1}};

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= StIdle;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    // Arbitration in IDLE; release the lock and hand priority over on tlast.
    always_comb begin
        w_state_next  = r_state;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            StIdle: begin
                if (s0_tvalid && (!s1_tvalid || !r_rr_ptr)) begin
                    w_state_next = StGnt0;
                end else if (s1_tvalid) begin
                    w_state_next = StGnt1;
                end
            end
            StGnt0: begin
                if (w_end0) begin
                    w_state_next  = StIdle;
                    w_rr_ptr_next = 1'b1;
                end
            end
            StGnt1: begin
                if (w_end1) begin
                    w_state_next  = StIdle;
                    w_rr_ptr_next = 1'b0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Grant is a one-hot view of the owning source.
    always_comb begin
        grant = 2'b00;
        case (r_state)
            StGnt0:  grant = 2'b01;
            StGnt1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Output register: load on an accepted beat, drop valid once drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_acc0) begin
            r_tdata  <= s0_tdata;
            r_tlast  <= s0_tlast;
            r_tvalid <= 1'b1;
        end else if (w_acc1) begin
            r_tdata  <= s1_tdata;
            r_tlast  <= s1_tlast;
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_FRAME_ARB_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt0;
    logic [CNT_W-1:0] r_frame_cnt1;

    // Count frames as their tlast beat leaves the source; wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
        end else begin
            if (w_end0) r_frame_cnt0 <= r_frame_cnt0 + 1'b1;
            if (w_end1) r_frame_cnt1 <= r_frame_cnt1 + 1'b1;
        end
    end

    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;
`else
    assign frame_cnt0 = '0;
    assign frame_cnt1 = '0;
`endif

endmodule

// File: tb/tb_axis_frame_arb.sv
// Self-checking bench for axis_frame_arb: vector table, directed corner
// sequences and a randomized run against a frame-level scoreboard.
module tb_axis_frame_arb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rstn;
    logic [DATA_W-1:0] s0_tdata;
    logic              s0_tvalid;
    logic              s0_tlast;
    logic              s0_tready;
    logic [DATA_W-1:0] s1_tdata;
    logic              s1_tvalid;
    logic              s1_tlast;
    logic              s1_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic [DATA_W/8-1:0] m_axis_tstrb;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  frame_cnt0;
    logic [CNT_W-1:0]  frame_cnt1;

    axis_frame_arb #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s0_tdata     (s0_tdata),
        .s0_tvalid    (s0_tvalid),
        .s0_tlast     (s0_tlast),
        .s0_tready    (s0_tready),
        .s1_tdata     (s1_tdata),
        .s1_tvalid    (s1_tvalid),
        .s1_tlast     (s1_tlast),
        .s1_tready    (s1_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant        (grant),
        .frame_cnt0   (frame_cnt0),
        .frame_cnt1   (frame_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        int unsigned cyc;
    } obs_t;

    // Table record: source-0 stimulus plus expected outputs for that cycle.
    typedef struct packed {
        logic        s0v;
        logic        s0l;
        logic [31:0] s0d;
        logic        mr;
        logic [1:0]  g;
        logic        s0r;
        logic        mv;
        logic [31:0] md;
        logic        ml;
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc_n   = 0;
    int unsigned gap_pct = 0;
    int unsigned rdy_pct = 100;

    beat_t q0[$];
    beat_t q1[$];
    beat_t e0[$];
    beat_t e1[$];
    obs_t  obs[$];
    vec_t  tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int src, input logic [31:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        if (src == 0) begin
            q0.push_back(b);
            e0.push_back(b);
        end else begin
            q1.push_back(b);
            e1.push_back(b);
        end
    endtask

    task automatic drive_srcs();
        if (!s0_tvalid && q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
            s0_tvalid = 1'b1;
            s0_tdata  = q0[0].data;
            s0_tlast  = q0[0].last;
        end
        if (!s1_tvalid && q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
            s1_tvalid = 1'b1;
            s1_tdata  = q1[0].data;
            s1_tlast  = q1[0].last;
        end
    endtask

    // One clock: note handshakes before the edge, then update the drivers.
    task automatic cyc();
        logic  a0;
        logic  a1;
        logic  mo;
        obs_t  ob;
        a0 = s0_tvalid && s0_tready;
        a1 = s1_tvalid && s1_tready;
        mo = m_axis_tvalid && m_axis_tready;
        ob.data = m_axis_tdata;
        ob.last = m_axis_tlast;
        ob.cyc  = cyc_n;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (mo) obs.push_back(ob);
        if (a0) begin
            void'(q0.pop_front());
            s0_tvalid = 1'b0;
            s0_tdata  = $urandom;
        end
        if (a1) begin
            void'(q1.pop_front());
            s1_tvalid = 1'b0;
            s1_tdata  = $urandom;
        end
        drive_srcs();
        m_axis_tready = ($urandom_range(99) < rdy_pct);
        #1;
    endtask

    task automatic run_until(input int unsigned n_obs, input int unsigned budget);
        for (int unsigned c = 0; c < budget && obs.size() < n_obs; c++) cyc();
        check("obs_count", 64'(obs.size()), 64'(n_obs));
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        s0_tvalid     = 1'b0;
        s0_tlast      = 1'b0;
        s0_tdata      = '0;
        s1_tvalid     = 1'b0;
        s1_tlast      = 1'b0;
        s1_tdata      = '0;
        m_axis_tready = 1'b1;
        gap_pct       = 0;
        rdy_pct       = 100;
        q0.delete();
        q1.delete();
        e0.delete();
        e1.delete();
        obs.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_a [6];
        logic [63:0] act;
        logic [63:0] exp;
        int          owner;
        int unsigned total;
        beat_t       eb;

        // Frame 0x10..0x13 at full rate, then 0x20..0x23 with a 3-cycle stall after beat 2.
        //          s0v   s0l   s0d     mr    g      s0r   mv    md      ml
        tbl[0]  = '{1'b1, 1'b0, 32'h10, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10, 1'b1, 2'b01, 1'b1, 1'b0, 32'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h11, 1'b1, 2'b01, 1'b1, 1'b1, 32'h10, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h12, 1'b1, 2'b01, 1'b1, 1'b1, 32'h11, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h13, 1'b1, 2'b01, 1'b1, 1'b1, 32'h12, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'b00, 1'b0, 1'b1, 32'h13, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h20, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h20, 1'b1, 2'b01, 1'b1, 1'b0, 32'h00, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h21, 1'b1, 2'b01, 1'b1, 1'b1, 32'h20, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h22, 1'b0, 2'b01, 1'b0, 1'b1, 32'h21, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h22, 1'b0, 2'b01, 1'b0, 1'b1, 32'h21, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h22, 1'b0, 2'b01, 1'b0, 1'b1, 32'h21, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h22, 1'b1, 2'b01, 1'b1, 1'b1, 32'h21, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 32'h23, 1'b1, 2'b01, 1'b1, 1'b1, 32'h22, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 32'h00, 1'b1, 2'b00, 1'b0, 1'b1, 32'h23, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00, 1'b0};

        // Reset state.
        do_reset();
        check("rst_tdata", 64'(m_axis_tdata), 64'h0);
        check("rst_tlast", 64'(m_axis_tlast), 64'h0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_cnt", 64'({frame_cnt0, frame_cnt1}), 64'h0);
        check("tstrb", 64'(m_axis_tstrb), 64'hF);

        // Vector table.
        for (int i = 0; i < 17; i++) begin
            s0_tvalid     = tbl[i].s0v;
            s0_tlast      = tbl[i].s0l;
            s0_tdata      = tbl[i].s0d;
            m_axis_tready = tbl[i].mr;
            #1;
            act = {53'h0, grant, s0_tready, s1_tready, m_axis_tvalid,
                   tbl[i].mv ? m_axis_tdata[3:0] : 4'h0, tbl[i].mv ? m_axis_tlast : 1'b0};
            exp = {53'h0, tbl[i].g, tbl[i].s0r, 1'b0, tbl[i].mv, tbl[i].md[3:0], tbl[i].ml};
            check($sformatf("vec%0d", i), act, exp);
            if (tbl[i].mv) check($sformatf("vec%0d_data", i), 64'(m_axis_tdata), 64'(tbl[i].md));
            @(posedge clk);
            @(negedge clk);
        end

        // Simultaneous 3-beat frames: s0 first, one bubble, then s1.
        do_reset();
        exp_a = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
        for (int i = 0; i < 3; i++) push_beat(0, exp_a[i], i == 2);
        for (int i = 0; i < 3; i++) push_beat(1, exp_a[i+3], i == 2);
        drive_srcs();
        #1;
        run_until(6, 40);
        if (obs.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("both_beat%0d", i), {31'h0, obs[i].data, obs[i].last},
                      {31'h0, exp_a[i], (i == 2 || i == 5)});
            end
            check("both_contig0", 64'(obs[1].cyc - obs[0].cyc), 64'd1);
            check("both_contig1", 64'(obs[2].cyc - obs[1].cyc), 64'd1);
            check("both_bubble", 64'(obs[3].cyc - obs[2].cyc), 64'd2);
            check("both_contig2", 64'(obs[5].cyc - obs[3].cyc), 64'd2);
        end
        // Priority should be back at source 0 after the s1 frame.
        repeat (3) cyc();
        obs.delete();
        push_beat(0, 32'hD0, 1'b1);
        push_beat(1, 32'hD1, 1'b1);
        drive_srcs();
        #1;
        run_until(2, 20);
        if (obs.size() == 2) check("rr_after_s1", 64'(obs[0].data), 64'hD0);

        // Continuous single-beat frames alternate s0, s1, s0, s1.
        do_reset();
        push_beat(0, 32'hC0, 1'b1);
        push_beat(0, 32'hC2, 1'b1);
        push_beat(1, 32'hC1, 1'b1);
        push_beat(1, 32'hC3, 1'b1);
        drive_srcs();
        #1;
        run_until(4, 40);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("single%0d", i), {31'h0, obs[i].data, obs[i].last},
                      {31'h0, 32'hC0 + 32'(i), 1'b1});
            end
        end

        // Asynchronous reset mid-frame, then a fresh s1 frame.
        do_reset();
        for (int i = 0; i < 5; i++) push_beat(0, 32'hE0 + 32'(i), i == 4);
        drive_srcs();
        #1;
        for (int c = 0; c < 20 && q0.size() > 3; c++) cyc();
        check("pre_rst_valid", 64'({m_axis_tvalid, grant}), 64'({1'b1, 2'b01}));
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst", 64'({m_axis_tvalid, grant, s0_tready, s1_tready, m_axis_tdata}),
              64'h0);
        @(negedge clk);
        s0_tvalid = 1'b0;
        q0.delete();
        e0.delete();
        obs.delete();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) push_beat(1, 32'hF0 + 32'(i), i == 2);
        drive_srcs();
        #1;
        check("post_rst_idle", 64'(grant), 64'h0);
        cyc();
        check("post_rst_grant", 64'(grant), 64'h2);
        run_until(3, 20);
        if (obs.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("post_rst_beat%0d", i), {31'h0, obs[i].data, obs[i].last},
                      {31'h0, 32'hF0 + 32'(i), (i == 2)});
            end
        end

        // Frame counters: 3 s0 frames and 2 s1 frames.
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i <= f; i++) push_beat(0, 32'h100 + 32'(i), i == f);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 2 - f; i++) push_beat(1, 32'h200 + 32'(i), i == 1 - f);
        drive_srcs();
        #1;
        run_until(9, 80);
        repeat (2) cyc();
`ifdef AXIS_FRAME_ARB_STATS_EN
        check("stats_cnt", 64'({frame_cnt0, frame_cnt1}), 64'({16'd3, 16'd2}));
`else
        check("stats_cnt", 64'({frame_cnt0, frame_cnt1}), 64'h0);
`endif

        // Randomized frames with gaps and backpressure against a scoreboard.
        do_reset();
        gap_pct = 30;
        rdy_pct = 70;
        total   = 0;
        for (int f = 0; f < 40; f++) begin
            for (int s = 0; s < 2; s++) begin
                int unsigned len;
                len = $urandom_range(6, 1);
                for (int unsigned i = 0; i < len; i++) begin
                    push_beat(s, {s[0], 15'(f), 16'(i)}, i == len - 1);
                    total++;
                end
            end
        end
        drive_srcs();
        #1;
        run_until(total, 5000);
        owner = -1;
        foreach (obs[k]) begin
            if (owner < 0) owner = int'(obs[k].data[31]);
            if (owner == 0 && e0.size() > 0) eb = e0.pop_front();
            else if (owner == 1 && e1.size() > 0) eb = e1.pop_front();
            else eb = '{data: 32'hDEAD_BEEF, last: 1'b0};
            check($sformatf("rand_beat%0d", k), {31'h0, obs[k].data, obs[k].last},
                  {31'h0, eb.data, eb.last});
            if (obs[k].last) owner = -1;
        end
        check("rand_drained", 64'(e0.size() + e1.size()), 64'h0);
        rdy_pct = 100;
        repeat (3) cyc();
`ifdef AXIS_FRAME_ARB_STATS_EN
        check("rand_cnt", 64'({frame_cnt0, frame_cnt1}), 64'({16'd40, 16'd40}));
`else
        check("rand_cnt", 64'({frame_cnt0, frame_cnt1}), 64'h0);
`endif
        check("rand_idle", 64'({grant, m_axis_tvalid}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_arb.md
Name: axis_frame_arb

Overview:
- Two-requester, frame-granular round-robin arbiter that shares one AXI4-Stream master output between two stream sources.
- Sits in front of the DMA S2MM stream input. Each source's frame is forwarded intact, from first beat through tlast, before the other source is granted.
- The output is a single registered stage with full tready backpressure.

Parameters:
- DATA_W, 32, stream data width in bits; must be a multiple of 8.
- CNT_W, 16, width of the per-source frame counters used by the optional stats feature.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- s0_tdata  in  DATA_W  source 0 data.
- s0_tvalid  in  1  source 0 valid.
- s0_tlast  in  1  source 0 end of frame.
- s0_tready  out  1  source 0 ready.
- s1_tdata  in  DATA_W  source 1 data.
- s1_tvalid  in  1  source 1 valid.
- s1_tlast  in  1  source 1 end of frame.
- s1_tready  out  1  source 1 ready.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tstrb  out  DATA_W/8  byte strobes, constant all ones.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tready  in  1  downstream ready.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- frame_cnt0  out  CNT_W  frames completed by source 0 (optional feature).
- frame_cnt1  out  CNT_W  frames completed by source 1 (optional feature).

Behaviour:
- Reset (asynchronous, rstn low) clears the following immediately, regardless of clock:
  - state = IDLE, rr_ptr = 0, grant = 00.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - s0_tready = s1_tready = 0, frame counters = 0.
- Reset mid-frame discards the in-flight beat and the rest of the frame ownership. After reset release, arbitration starts fresh from source 0 priority.
- State machine: IDLE, GNT0, GNT1.
- IDLE transitions:
  - Only s0_tvalid high -> GNT0.
  - Only s1_tvalid high -> GNT1.
  - Both high -> the source selected by rr_ptr (0 -> source 0, 1 -> source 1).
  - Neither high -> stay in IDLE.
  - The decision is registered; the transition happens at the next clock edge.
- GNTx transitions:
  - On an accepted beat (sx_tvalid & sx_tready & sx_tlast) -> IDLE.
  - On that same edge, rr_ptr is set to the other source.
- While in GNTx, the frame is locked to source x: the other source's tvalid is ignored and its tready is held 0.
- s_tready rule: sx_tready = (state == GNTx) & (!m_axis_tvalid | m_axis_tready). It is combinational from the registered state and the output register. s_tready in IDLE is always 0.
- Output register:
  - Load condition: an accepted source beat.
  - On load: m_axis_tdata <= sx_tdata, m_axis_tlast <= sx_tlast, m_axis_tvalid <= 1.
  - Clear: m_axis_tvalid <= 0 when m_axis_tready is high and no beat is loaded that cycle.
  - While m_axis_tvalid is high and m_axis_tready is low, data and last are held stable.
- Latency:
  - One cycle from source acceptance to m_axis_tvalid.
  - First beat of a frame: source valid seen in IDLE at cycle N, grant at N+1, beat accepted at N+1, output valid at N+2.
- Throughput:
  - One beat per cycle within a frame while m_axis_tready is held high.
  - Exactly one IDLE bubble cycle between consecutive frames.
- Single-beat frame (tlast on the first beat): GNTx lasts one accepted beat, then IDLE.
- Downstream stall on the tlast beat: the grant is held until that beat is accepted from the source. The output register still holds the beat afterwards, and that is legal.
- m_axis_tstrb is tied to all ones.
- grant mirrors the state: GNT0 = 01, GNT1 = 10, IDLE = 00.

Optional Feature:
- Macro: AXIS_FRAME_ARB_STATS_EN.
- Defined:
  - frame_cnt0 / frame_cnt1 increment by 1 on each accepted tlast beat of the corresponding source.
  - The counters wrap modulo 2^CNT_W.
  - Reset to 0.
- Not defined: frame_cnt0 and frame_cnt1 are tied to 0 and no counter logic is synthesized.

Test Plan:
- Only s0 sends a 4-beat frame (data 0x10..0x13) with tready = 1 -> grant = 01; m_axis carries 0x10..0x13 on 4 consecutive cycles, tlast only on 0x13; grant returns to 00.
- s0 and s1 both send 3-beat frames starting the same cycle after reset -> s0 frame is forwarded first, then one idle cycle, then the s1 frame; beats are never interleaved; rr_ptr = 0 after the s1 frame.
- Single-beat frames with s0 and s1 continuously valid, 4 frames total -> output frame order is s0, s1, s0, s1; tlast is set on every output beat.
- s0 sends a 4-beat frame while m_axis_tready is held low for 3 cycles after beat 2 -> the beat 2 output is held stable with tvalid high; s0_tready = 0 during the stall; there is no data loss or duplication.
- rstn is pulsed low asynchronously mid-frame on beat 2 of 5 -> m_axis_tvalid, grant and both treadys go to 0 without a clock edge; after release, a new s1 frame is granted normally.
- With AXIS_FRAME_ARB_STATS_EN, 3 s0 frames and 2 s1 frames -> frame_cnt0 = 3, frame_cnt1 = 2. Without the macro, both counters read 0.
